// File: rtl/pulse_gen_mc.sv
// Multi-channel programmable pulse generator: each channel runs continuous,
// burst or one-shot pulse trains timed by a shared tick prescaler.
module pulse_gen_mc #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int BURST_W  = 8,
    parameter int PRESCALE = 100
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        turbosim,
    input  logic                                        cfg_we,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                  cfg_sel,
    input  logic [CNT_W-1:0]                            cfg_data,
    input  logic [CHANNELS-1:0]                         start,
    input  logic [CHANNELS-1:0]                         stop,
    output logic [CHANNELS-1:0]                         signal_out,
    output logic [CHANNELS-1:0]                         signal_cycle,
    output logic [CHANNELS-1:0]                         busy,
    output logic [CHANNELS-1:0]                         done
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CH_W:0]   CH_LIM  = (CH_W + 1)'(CHANNELS);

    typedef enum logic {IDLE, RUN} state_t;

    // One-shot is a burst of one; a zero burst count also means one.
    function automatic logic [BURST_W-1:0] burst_len(input logic [1:0] mode,
                                                     input logic [BURST_W-1:0] count);
        if (mode == 2'd2 || count == '0)
            return BURST_W'(1);
        return count;
    endfunction

    function automatic logic is_burst(input logic [1:0] mode);
        return (mode == 2'd1) || (mode == 2'd2);
    endfunction

    logic [PS_W-1:0] pre_cnt;
    logic            tick;
    logic            cfg_hit;

    always_ff @(posedge clk) begin
        if (!reset)
            pre_cnt <= '0;
        else if (pre_cnt == PS_LAST)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + PS_W'(1);
    end

    assign tick    = turbosim | (pre_cnt == PS_LAST);
    assign cfg_hit = cfg_we & ({1'b0, cfg_ch} < CH_LIM);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0]   period_r, width_r, period_sh, width_sh;
        logic [CNT_W-1:0]   cyc_cnt, cyc_nx;
        logic [BURST_W-1:0] count_r, rem, rem_nx;
        logic [1:0]         mode_r, mode_sh;
        state_t             state, state_nx;
        logic               load_sh, out_nx, strobe_nx, done_nx, wr;
        logic               out_q, cyc_q, busy_q, done_q;

        assign wr = cfg_hit & (cfg_ch == CH_W'(c));

        always_comb begin
            state_nx  = state;
            cyc_nx    = cyc_cnt;
            rem_nx    = rem;
            load_sh   = 1'b0;
            out_nx    = 1'b0;
            strobe_nx = 1'b0;
            done_nx   = 1'b0;
            case (state)
                IDLE: begin
                    if (start[c] && !stop[c] && period_r != '0) begin
                        state_nx  = RUN;
                        cyc_nx    = '0;
                        load_sh   = 1'b1;
                        rem_nx    = burst_len(mode_r, count_r);
                        strobe_nx = 1'b1;
                        out_nx    = (width_r != '0);
                    end
                end
                RUN: begin
                    if (stop[c]) begin
                        state_nx = IDLE;
                    end else if (tick && cyc_cnt == period_sh - CNT_W'(1)) begin
                        if (is_burst(mode_sh) && rem <= BURST_W'(1)) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end else begin
                            // New period: shadows pick up any config written meanwhile.
                            cyc_nx  = '0;
                            load_sh = 1'b1;
                            if (is_burst(mode_sh))
                                rem_nx = rem - BURST_W'(1);
                            if (period_r == '0) begin
                                state_nx = IDLE;
                            end else begin
                                strobe_nx = 1'b1;
                                out_nx    = (width_r != '0);
                            end
                        end
                    end else begin
                        if (tick)
                            cyc_nx = cyc_cnt + CNT_W'(1);
                        out_nx = (cyc_nx < width_sh);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                state    <= IDLE;
                period_r <= '0;
                width_r  <= '0;
                count_r  <= BURST_W'(1);
                mode_r   <= 2'd0;
                out_q    <= 1'b0;
                cyc_q    <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                state  <= state_nx;
                out_q  <= out_nx;
                cyc_q  <= strobe_nx;
                busy_q <= (state_nx == RUN);
                done_q <= done_nx;
                if (wr) begin
                    case (cfg_sel)
                        2'd0: period_r <= cfg_data;
                        2'd1: width_r  <= cfg_data;
                        2'd2: count_r  <= cfg_data[BURST_W-1:0];
                        2'd3: mode_r   <= cfg_data[1:0];
                    endcase
                end
            end
        end

        // Datapath state is only meaningful in RUN and is seeded on start.
        always_ff @(posedge clk) begin
            cyc_cnt <= cyc_nx;
            rem     <= rem_nx;
            if (load_sh) begin
                period_sh <= period_r;
                width_sh  <= width_r;
                mode_sh   <= mode_r;
            end
        end

        assign signal_out[c]   = out_q;
        assign signal_cycle[c] = cyc_q;
        assign busy[c]         = busy_q;
        assign done[c]         = done_q;
    end

endmodule
